// File: rtl/serial_alu_pkg.sv
// Shared types and helpers for the serial ALU: opcode and FSM state enums,
// frame-length function and the frame parity helper.
package serial_alu_pkg;

    typedef enum logic [2:0] {
        OP_CLR = 3'd0,
        OP_ADD = 3'd1,
        OP_SUB = 3'd2,
        OP_MUL = 3'd3,
        OP_DIV = 3'd4,
        OP_MOD = 3'd5,
        OP_AND = 3'd6,
        OP_XOR = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        ST_HUNT = 2'd0,
        ST_LOAD = 2'd1,
        ST_EXEC = 2'd2
    } state_e;

    // Longest frame for the widest legal operand (W = 16).
    localparam int FRAME_MAX = 37;

    // Frame: exe + 3-bit op + A + B + parity.
    function automatic int frame_len(input int w);
        return (2 * w) + 5;
    endfunction

    // Returns 1 when the frame has odd parity, i.e. the even-parity check fails.
    function automatic logic parity_odd(input logic [FRAME_MAX-1:0] v);
        return ^v;
    endfunction

endpackage

// File: rtl/serial_pre_det.sv
// Preamble detector: PRE_LEN-bit history of consumed bits, oldest bit at MSB.
// match is asserted in the cycle whose consumed bit completes the pattern, so
// the very next consumed bit is the first frame bit.
module serial_pre_det #(
    parameter int                 PRE_LEN = 4,
    parameter logic [PRE_LEN-1:0] PRE     = 4'b1010
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic bit_in,
    input  logic bit_en,
    output logic match
);

    logic [PRE_LEN-1:0] hist_q;
    logic [PRE_LEN-1:0] hist_d;

    // History after shifting in the current bit; also the compare operand.
    always_comb begin
        hist_d = {hist_q[PRE_LEN-2:0], bit_in};
    end

    assign match = bit_en & (hist_d == PRE);

    // History register: cleared by reset or clr, otherwise shifts on consumed bits.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            hist_q <= {PRE_LEN{1'b0}};
        end else if (bit_en) begin
            hist_q <= hist_d;
        end else begin
            hist_q <= hist_q;
        end
    end

endmodule

// File: rtl/serial_alu_p.sv
// Serial ALU: hunts for a preamble, captures an LSB-first frame
// (exe, op, A, B, parity), executes it and presents a registered result
// with a one-cycle res_valid pulse during EXEC.
module serial_alu_p
    import serial_alu_pkg::*;
#(
    parameter int                 W       = 8,
    parameter int                 PRE_LEN = 4,
    parameter logic [PRE_LEN-1:0] PRE     = 4'b1010
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           data_in,
    input  logic           data_en,
    output logic [2*W-1:0] res_out,
    output logic           res_valid,
    output logic           err,
    output logic           busy
);

    localparam int F  = frame_len(W);
    localparam int CW = $clog2(F);

    state_e         state_q;
    logic [CW-1:0]  cnt_q;
    logic [F-1:0]   frame_q;
    logic [F-1:0]   frame_d;
    logic [2*W-1:0] res_out_q;
    logic           res_valid_q;
    logic           err_q;
    logic           busy_q;

    logic           hunt_en_s;
    logic           hunt_clr_s;
    logic           pre_match_s;
    logic           last_bit_s;
    logic [W-1:0]   opa_s;
    logic [W-1:0]   opb_s;
    logic [2*W-1:0] a_ext_s;
    logic [2*W-1:0] b_ext_s;
    logic [2*W-1:0] alu_res_s;
    logic           alu_err_s;

    // Preamble search runs only in HUNT; history is held clear otherwise so
    // every return to HUNT starts from an empty history.
    assign hunt_en_s  = data_en & (state_q == ST_HUNT);
    assign hunt_clr_s = (state_q != ST_HUNT);

    serial_pre_det #(
        .PRE_LEN (PRE_LEN),
        .PRE     (PRE)
    ) u_pre_det (
        .clk    (clk),
        .rst    (rst),
        .clr    (hunt_clr_s),
        .bit_in (data_in),
        .bit_en (hunt_en_s),
        .match  (pre_match_s)
    );

    // Frame register next state: drop the consumed bit into its slot.
    always_comb begin
        frame_d = frame_q;
        if ((state_q == ST_LOAD) && data_en) begin
            frame_d[cnt_q] = data_in;
        end else begin
            frame_d = frame_q;
        end
    end

    assign last_bit_s = (state_q == ST_LOAD) && data_en && (cnt_q == CW'(F - 1));

    assign opa_s   = frame_d[4 +: W];
    assign opb_s   = frame_d[4 + W +: W];
    assign a_ext_s = {{W{1'b0}}, opa_s};
    assign b_ext_s = {{W{1'b0}}, opb_s};

    // Arithmetic on the completed frame; result is held unless a good,
    // executable frame selects a new value.
    always_comb begin
        alu_res_s = res_out_q;
        alu_err_s = 1'b0;
        if (parity_odd(FRAME_MAX'(frame_d))) begin
            alu_err_s = 1'b1;
        end else if (frame_d[0]) begin
            case (op_e'(frame_d[3:1]))
                OP_CLR: alu_res_s = {(2*W){1'b0}};
                OP_ADD: alu_res_s = a_ext_s + b_ext_s;
                OP_SUB: alu_res_s = a_ext_s - b_ext_s;
                OP_MUL: alu_res_s = a_ext_s * b_ext_s;
                OP_DIV: begin
                    if (opb_s == {W{1'b0}}) begin
                        alu_res_s = {(2*W){1'b1}};
                        alu_err_s = 1'b1;
                    end else begin
                        alu_res_s = a_ext_s / b_ext_s;
                    end
                end
                OP_MOD: begin
                    if (opb_s == {W{1'b0}}) begin
                        alu_res_s = {(2*W){1'b1}};
                        alu_err_s = 1'b1;
                    end else begin
                        alu_res_s = a_ext_s % b_ext_s;
                    end
                end
                OP_AND: alu_res_s = a_ext_s & b_ext_s;
                OP_XOR: alu_res_s = a_ext_s ^ b_ext_s;
                default: alu_res_s = res_out_q;
            endcase
        end else begin
            alu_res_s = res_out_q;
        end
    end

    // Control FSM with registered outputs; result lands as EXEC is entered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_HUNT;
            cnt_q       <= {CW{1'b0}};
            frame_q     <= {F{1'b0}};
            res_out_q   <= {(2*W){1'b0}};
            res_valid_q <= 1'b0;
            err_q       <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            res_valid_q <= 1'b0;
            err_q       <= 1'b0;
            case (state_q)
                ST_HUNT: begin
                    if (pre_match_s) begin
                        state_q <= ST_LOAD;
                        cnt_q   <= {CW{1'b0}};
                        busy_q  <= 1'b1;
                    end else begin
                        busy_q  <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    busy_q <= 1'b1;
                    if (data_en) begin
                        frame_q <= frame_d;
                        if (last_bit_s) begin
                            state_q     <= ST_EXEC;
                            cnt_q       <= {CW{1'b0}};
                            res_out_q   <= alu_res_s;
                            res_valid_q <= 1'b1;
                            err_q       <= alu_err_s;
                        end else begin
                            cnt_q <= cnt_q + CW'(1);
                        end
                    end
                end
                ST_EXEC: begin
                    state_q <= ST_HUNT;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= ST_HUNT;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign res_out   = res_out_q;
    assign res_valid = res_valid_q;
    assign err       = err_q;
    assign busy      = busy_q;

endmodule

// File: doc/serial_alu_p.md
SERIAL_ALU_P -- requirements
Module: serial_alu_p

Interface
REQ-001 SHALL provide parameter W, default 8: operand width in bits, legal range 4..16.
REQ-002 SHALL provide parameter PRE_LEN, default 4: preamble length in bits, legal range 2..8.
REQ-003 SHALL provide parameter PRE, default 4'b1010: preamble pattern, oldest bit at MSB.
REQ-004 SHALL have port clk, input, 1: clock; all state updates on posedge clk.
REQ-005 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-006 SHALL have port data_in, input, 1: serial data bit.
REQ-007 SHALL have port data_en, input, 1: data_in is a valid bit this cycle.
REQ-008 SHALL have port res_out, output, 2W: last computed result, held between updates.
REQ-009 SHALL have port res_valid, output, 1: one-cycle pulse when a frame completes.
REQ-010 SHALL have port err, output, 1: qualifies res_valid; 1 = parity error or divide-by-zero.
REQ-011 SHALL have port busy, output, 1: high while in LOAD or EXEC.

Function
REQ-012 SHALL consume a bit only in cycles where data_en=1; cycles with data_en=0 change no state.
REQ-013 SHALL implement FSM states HUNT, LOAD and EXEC.
REQ-014 HUNT: shift each consumed bit into a PRE_LEN-bit history; when the history equals PRE, go to LOAD with bit count 0; overlapping matches count.
REQ-015 LOAD: capture F = 2W+5 bits LSB-first in this order: exe (bit 0), op[2:0], A[W-1:0], B[W-1:0], then a parity bit.
REQ-016 LOAD: disable preamble search; on the F-th consumed bit go to EXEC.
REQ-017 Parity check SHALL pass when the XOR of all F frame bits is 0 (even parity).
REQ-018 EXEC lasts exactly one cycle, then returns to HUNT with the preamble history cleared.
REQ-019 In EXEC, res_valid SHALL be 1, so res_valid rises the cycle after the final frame bit is consumed.
REQ-020 Parity fail: err=1, res_out unchanged.
REQ-021 Parity ok and exe=0: err=0, res_out unchanged.
REQ-022 Parity ok and exe=1: res_out SHALL be updated per op, operands zero-extended to 2W bits:
  - 0 CLR: 0
  - 1 ADD: A+B
  - 2 SUB: (A-B) mod 2^(2W)
  - 3 MUL: A*B
  - 4 DIV: A/B
  - 5 MOD: A%B
  - 6 AND: A&B
  - 7 XOR: A^B
REQ-023 For DIV or MOD with B=0: res_out SHALL be all ones and err=1.
REQ-024 res_out SHALL update in the same cycle that res_valid is asserted.
REQ-025 busy SHALL be high in LOAD and EXEC and low in HUNT.
REQ-026 data_in and data_en during EXEC SHALL be ignored; a bit presented in EXEC is lost.

Reset
REQ-027 rst=1 SHALL force HUNT, clear the preamble history, bit count and frame register, and set res_out=0, res_valid=0, err=0, busy=0.
REQ-028 rst asserted mid-frame SHALL abort the frame with no res_valid pulse; rst has priority over data_en.

Structure
REQ-029 A package serial_alu_pkg SHALL hold the op enum (CLR..XOR), the FSM state enum, and the frame-length function F(W).
REQ-030 A sub-module serial_pre_det SHALL contain the parameterised preamble shift-register and compare, with inputs clk, rst, clr, bit_in, bit_en and output match.
REQ-031 Arithmetic SHALL be a single combinational block evaluated from the frame register in EXEC.

Verification (W=8, PRE=1010)
REQ-032 Preamble 1010, exe=1, op=1, A=200, B=100, good parity -> res_out=16'h012C, res_valid one cycle, err=0.
REQ-033 Same frame with the parity bit flipped -> res_valid=1, err=1, res_out keeps its previous value.
REQ-034 op=4, A=50, B=0 -> res_out=16'hFFFF, err=1; then op=2, A=3, B=5 -> res_out=16'hFFFE.
REQ-035 op=3, A=255, B=255 with data_en toggling 1/0 every cycle -> res_out=16'hFE01, latency counted in consumed bits only.
REQ-036 Stream 101010 followed by a frame -> match on the first 1010, frame captured from the following bit; a 1010 inside the payload does not restart capture.
REQ-037 rst pulsed after 10 frame bits, then a full valid frame -> no pulse for the aborted frame, a correct result for the second frame.
